// File: rtl/keypad_pkg.sv
// Shared sizes and enums for the keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_e;
endpackage

// File: rtl/keypad_scan_ctrl_tick_gen.sv
// Single-cycle enable tick every TICK_DIV clocks; counts 0..TICK_DIV-1 and wraps.
module scan_tick_gen #(
  parameter int TICK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == TC) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TC);
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column walk, per-frame classification, debounce FSM, valid/ack report.
// States: IDLE no key | CONFIRM debouncing a press | HELD key down | RELEASE debouncing a release
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_HZ          = 48_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_n,
  output logic [3:0]        col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_down,
  output logic              key_overrun
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic                tick, frame_end, report;
  logic [1:0]          col_q;
  logic [1:0]          acc_hits_q, acc_hits_d;
  logic [CODE_W-1:0]   acc_code_q, acc_code_d;
  logic [2:0]          col_hits, total_hits;
  logic [1:0]          col_row;
  logic [CODE_W-1:0]   frame_code;
  frame_e              frame_res;
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [CODE_W-1:0]   code_q;
  logic                valid_q, overrun_q;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
  end

  // Hit count saturates at 2: anything beyond one intersection is MULTI.
  always_comb begin
    total_hits = {1'b0, acc_hits_q} + col_hits;
    acc_hits_d = (total_hits > 3'd1) ? 2'd2 : total_hits[1:0];
    acc_code_d = (col_hits == 3'd1) ? {col_row, col_q} : acc_code_q;
    frame_code = acc_code_d;
    if (total_hits == 3'd0)      frame_res = NONE;
    else if (total_hits == 3'd1) frame_res = SINGLE;
    else                         frame_res = MULTI;
  end

  assign frame_end = tick && (col_q == 2'(NUM_COLS - 1));
  assign cnt_inc   = cnt_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      col_q      <= '0;
      acc_hits_q <= '0;
      acc_code_q <= '0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      if (tick) begin
        col_q <= col_q + 2'd1;
        if (frame_end) begin
          acc_hits_q <= '0;
          acc_code_q <= '0;
        end else begin
          acc_hits_q <= acc_hits_d;
          acc_code_q <= acc_code_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    report  = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: if (frame_res == SINGLE) begin
          cand_d = frame_code;
          cnt_d  = 4'd1;
          if (DEB <= 4'd1) begin
            state_d = HELD;
            report  = 1'b1;
          end else begin
            state_d = CONFIRM;
          end
        end
        CONFIRM: if (frame_res == SINGLE && frame_code == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DEB) begin
            state_d = HELD;
            report  = 1'b1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        HELD: if (frame_res == NONE) begin
          cnt_d   = 4'd1;
          state_d = (DEB <= 4'd1) ? IDLE : RELEASE;
        end
        RELEASE: if (frame_res == NONE) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DEB) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          state_d = HELD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    col_n    = ~(4'b0001 << col_q);
    key_down = (state_q == HELD) || (state_q == RELEASE);
  end

  // An ack on the report cycle frees the slot, so the new key wins over an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (report) begin
        if (!valid_q || key_ack) begin
          code_q  <= cand_d;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_overrun = overrun_q;
endmodule
